// File: rtl/ethpipe_pkg.sv
// Shared Ethernet pipeline definitions: framing constants, TX state encoding, CRC-32 helpers.
// The TX_CRC_GEN_EN build of gmii_tx_framer uses the CRC helpers through crc32_d8.
package ethpipe_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [11:0] MIN_FRAME_LEN = 12'd60;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_FCS      = 3'd3,
        ST_IFG      = 3'd4
    } tx_state_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) begin
            r[b] = v[31-b];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC32_POLY_REFL = bitrev32(CRC32_POLY);

    // Reflected (LSB-first) update: bit 0 of each byte enters the register first.
    function automatic logic [31:0] crc32_next_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ data[b]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 register (reflected, init all-ones, no final inversion here).
// Shared between the TX FCS generator and the RX FCS checker.
module crc32_d8
    import ethpipe_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    always_comb begin
        w_crc_next = crc32_next_byte(r_crc, i_data);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= CRC32_INIT;
        end else if (i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/gmii_tx_framer.sv
// Reads one frame from the TX slot RAM and drives preamble/SFD, data and IFG onto GMII.
// Define TX_CRC_GEN_EN to pad short frames to 60 bytes and append a generated FCS.
module gmii_tx_framer
    import ethpipe_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR     = 12'd1,
    parameter logic [11:0] MAX_FRAME_LEN = 12'd1518,
    parameter int          IFG_CYCLES    = 12
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic        tx_start,
    input  logic [11:0] tx_frame_len,
    output logic [11:0] slot_tx_eth_address,
    output logic        slot_tx_eth_rd_en,
    input  logic [15:0] slot_tx_eth_q,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic [63:0] tx_timestamp,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [11:0] IFG_LAST = 12'(IFG_CYCLES - 1);

    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [11:0] r_cnt;
    logic [11:0] r_len;
    logic [11:0] r_words;
    logic [11:0] r_addr;
    logic [15:0] r_hold;
    logic        r_rd_d;
    logic        r_done;
    logic [63:0] r_ts;

    logic        w_accept;
    logic        w_zero_req;
    logic [11:0] w_len_clip;
    logic [11:0] w_nwords;
    logic [11:0] w_data_last;
    logic        w_rd_en;
    logic        w_rd_next;
    logic        w_tx_en;
    logic [7:0]  w_txd;

    assign w_zero_req  = (r_state == ST_IDLE) && tx_start && (tx_frame_len == 12'd0);
    assign w_accept    = (r_state == ST_IDLE) && tx_start && (tx_frame_len != 12'd0);
    assign w_len_clip  = (tx_frame_len > MAX_FRAME_LEN) ? MAX_FRAME_LEN : tx_frame_len;
    assign w_nwords    = (r_len + 12'd1) >> 1;

`ifdef TX_CRC_GEN_EN
    logic [31:0] w_crc;
    logic [31:0] w_fcs;

    assign w_data_last = (r_len < MIN_FRAME_LEN) ? (MIN_FRAME_LEN - 12'd1) : (r_len - 12'd1);
    assign w_fcs       = ~w_crc;

    crc32_d8 u_crc (
        .i_clk  (gmii_tx_clk),
        .i_rst  (sys_rst),
        .i_init (w_accept),
        .i_en   (r_state == ST_DATA),
        .i_data (w_txd),
        .o_crc  (w_crc)
    );
`else
    assign w_data_last = r_len - 12'd1;
`endif

    // State register
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_state_next = ST_PREAMBLE;
            ST_PREAMBLE: if (r_cnt == 12'd7) w_state_next = ST_DATA;
            ST_DATA: begin
                if (r_cnt == w_data_last) begin
`ifdef TX_CRC_GEN_EN
                    w_state_next = ST_FCS;
`else
                    w_state_next = ST_IFG;
`endif
                end
            end
            ST_FCS:      if (r_cnt == 12'd3) w_state_next = ST_IFG;
            ST_IFG:      if (r_cnt == IFG_LAST) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Output logic; word n is fetched two cycles before its low byte goes on the wire
    always_comb begin
        w_tx_en   = 1'b0;
        w_txd     = 8'h00;
        w_rd_en   = 1'b0;
        w_rd_next = 1'b0;
        case (r_state)
            ST_PREAMBLE: begin
                w_tx_en   = 1'b1;
                w_txd     = (r_cnt == 12'd7) ? SFD_BYTE : PREAMBLE_BYTE;
                w_rd_en   = (r_cnt == 12'd6);
                w_rd_next = (r_cnt == 12'd5) || ((r_cnt == 12'd7) && (r_words < w_nwords));
            end
            ST_DATA: begin
                w_tx_en = 1'b1;
                if (r_cnt < r_len) begin
                    w_txd = r_cnt[0] ? r_hold[15:8] : r_hold[7:0];
                end
                w_rd_en   = !r_cnt[0] && (r_words < w_nwords);
                w_rd_next = r_cnt[0] && (r_words < w_nwords);
            end
`ifdef TX_CRC_GEN_EN
            ST_FCS: begin
                w_tx_en = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_txd = w_fcs[7:0];
                    2'd1:    w_txd = w_fcs[15:8];
                    2'd2:    w_txd = w_fcs[23:16];
                    default: w_txd = w_fcs[31:24];
                endcase
            end
`endif
            default: begin
                w_tx_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt   <= 12'd0;
            r_len   <= 12'd0;
            r_words <= 12'd0;
            r_addr  <= 12'd0;
            r_hold  <= 16'd0;
            r_rd_d  <= 1'b0;
            r_done  <= 1'b0;
            r_ts    <= 64'd0;
        end else begin
            if ((w_state_next != r_state) || (r_state == ST_IDLE)) begin
                r_cnt <= 12'd0;
            end else begin
                r_cnt <= r_cnt + 12'd1;
            end
            if (w_accept) begin
                r_len   <= w_len_clip;
                r_words <= 12'd0;
            end else if (w_rd_en) begin
                r_words <= r_words + 12'd1;
            end
            // Address moves only ahead of a read, so it keeps the last fetched word when idle
            if (w_rd_next) begin
                r_addr <= (r_state == ST_PREAMBLE && r_cnt == 12'd5) ? BASE_ADDR : r_addr + 12'd1;
            end
            r_rd_d <= w_rd_en;
            if (r_rd_d) begin
                r_hold <= slot_tx_eth_q;
            end
            if (r_state == ST_PREAMBLE && r_cnt == 12'd7) begin
                r_ts <= global_counter;
            end
            r_done <= w_zero_req || (r_state == ST_IFG && r_cnt == IFG_LAST);
        end
    end

    assign slot_tx_eth_address = r_addr;
    assign slot_tx_eth_rd_en   = w_rd_en;
    assign gmii_tx_en          = w_tx_en;
    assign gmii_txd            = w_txd;
    assign tx_timestamp        = r_ts;
    assign tx_busy             = (r_state != ST_IDLE);
    assign tx_done             = r_done;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer against a frame-level reference model.
// Build with +define+TX_CRC_GEN_EN to exercise padding and FCS generation.
module tb_gmii_tx_framer;

    localparam logic [11:0] TB_BASE     = 12'hFF0;
    localparam int          TB_MAX_LEN  = 1518;
    localparam int          TB_IFG      = 12;
    localparam int          TB_MIN_LEN  = 60;
    localparam logic [31:0] TB_RESIDUE  = 32'hC704DD7B;

    logic        gmii_tx_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] global_counter;
    logic        tx_start;
    logic [11:0] tx_frame_len;
    logic [11:0] slot_tx_eth_address;
    logic        slot_tx_eth_rd_en;
    logic [15:0] slot_tx_eth_q = 16'h0000;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic [63:0] tx_timestamp;
    logic        tx_busy;
    logic        tx_done;

    int vectors     = 0;
    int miscompares = 0;

    gmii_tx_framer #(
        .BASE_ADDR     (TB_BASE),
        .MAX_FRAME_LEN (12'(TB_MAX_LEN)),
        .IFG_CYCLES    (TB_IFG)
    ) dut (
        .gmii_tx_clk         (gmii_tx_clk),
        .sys_rst             (sys_rst),
        .global_counter      (global_counter),
        .tx_start            (tx_start),
        .tx_frame_len        (tx_frame_len),
        .slot_tx_eth_address (slot_tx_eth_address),
        .slot_tx_eth_rd_en   (slot_tx_eth_rd_en),
        .slot_tx_eth_q       (slot_tx_eth_q),
        .gmii_txd            (gmii_txd),
        .gmii_tx_en          (gmii_tx_en),
        .tx_timestamp        (tx_timestamp),
        .tx_busy             (tx_busy),
        .tx_done             (tx_done)
    );

    // Clock / time base
    always #5 gmii_tx_clk = ~gmii_tx_clk;

    int unsigned cyc = 0;
    logic [63:0] gc_base = 64'd0;
    always @(posedge gmii_tx_clk) cyc <= cyc + 1;
    assign global_counter = gc_base + 64'(cyc) * 64'd7;

    // Slot RAM with one cycle read latency
    logic [15:0] mem [4096];
    always @(posedge gmii_tx_clk) begin
        if (slot_tx_eth_rd_en) slot_tx_eth_q <= mem[slot_tx_eth_address];
    end

    // Wire monitor
    logic        mon_en = 1'b0;
    logic [7:0]  wire_q[$];
    int          wire_first;
    int          rd_cyc_q[$];
    logic [11:0] rd_addr_q[$];
    int          done_q[$];
    int          busy_n;
    int          busy_first;
    int          idle_txd_err;

    always @(negedge gmii_tx_clk) begin
        if (mon_en) begin
            if (gmii_tx_en) begin
                if (wire_q.size() == 0) wire_first = int'(cyc);
                wire_q.push_back(gmii_txd);
            end else if (gmii_txd !== 8'h00) begin
                idle_txd_err++;
            end
            if (slot_tx_eth_rd_en) begin
                rd_cyc_q.push_back(int'(cyc));
                rd_addr_q.push_back(slot_tx_eth_address);
            end
            if (tx_done) done_q.push_back(int'(cyc));
            if (tx_busy) begin
                if (busy_n == 0) busy_first = int'(cyc);
                busy_n++;
            end
        end
    end

    // Scoreboard helpers
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    function automatic int wire_len(input int l);
`ifdef TX_CRC_GEN_EN
        return ((l < TB_MIN_LEN) ? TB_MIN_LEN : l) + 4;
`else
        return l;
`endif
    endfunction

    function automatic logic [7:0] slot_byte(input int i);
        logic [15:0] w;
        w = mem[12'(TB_BASE + 12'(i / 2))];
        return (i % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    task automatic build_exp(input int l);
        int dl;
        logic [7:0] b;
`ifdef TX_CRC_GEN_EN
        logic [31:0] c;
        c = 32'hFFFFFFFF;
`endif
        exp_q.delete();
        if (l == 0) return;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        dl = l;
`ifdef TX_CRC_GEN_EN
        if (dl < TB_MIN_LEN) dl = TB_MIN_LEN;
`endif
        for (int i = 0; i < dl; i++) begin
            b = (i < l) ? slot_byte(i) : 8'h00;
            exp_q.push_back(b);
`ifdef TX_CRC_GEN_EN
            c = crc_byte(c, b);
`endif
        end
`ifdef TX_CRC_GEN_EN
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
`endif
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    endtask

    // One request, observed for its whole lifetime plus 40 quiet cycles
    task automatic run_frame(input int len, input bit stray);
        int l, w, t, exp_done, span, n_bad, nwords, n_chk, stray_cyc;
        logic [31:0] rc;
        l = (len > TB_MAX_LEN) ? TB_MAX_LEN : len;
        build_exp(l);
        wire_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete(); done_q.delete();
        wire_first = -1; busy_n = 0; busy_first = -1; idle_txd_err = 0;
        mon_en = 1'b1;
        @(negedge gmii_tx_clk);
        t = int'(cyc);
        tx_frame_len = 12'(len);
        tx_start = 1'b1;
        w = (l == 0) ? 0 : wire_len(l);
        exp_done = (l == 0) ? t + 1 : t + 21 + w;
        span = exp_done - t + 40;
        stray_cyc = t + 2 + int'($urandom_range(0, (w > 2) ? w : 2));
        for (int k = 0; k < span; k++) begin
            @(negedge gmii_tx_clk);
            tx_start = stray && (int'(cyc) == t + 40 || int'(cyc) == stray_cyc || int'(cyc) == exp_done - 1);
            if (stray) tx_frame_len = 12'($urandom_range(1, 100));
        end
        tx_start = 1'b0;
        mon_en = 1'b0;

        check("done_count", done_q.size(), 1);
        check("done_cycle", (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        check("busy_cycles", busy_n, (l == 0) ? 0 : 20 + w);
        if (l > 0) check("busy_first", busy_first, t + 1);
        check("wire_len", wire_q.size(), exp_q.size());
        n_chk = (wire_q.size() < exp_q.size()) ? wire_q.size() : exp_q.size();
        n_bad = 0;
        for (int i = 0; i < n_chk; i++) if (wire_q[i] !== exp_q[i]) n_bad++;
        check("wire_bytes_bad", n_bad, 0);
        if (l > 0) check("tx_en_first", wire_first, t + 1);
        check("txd_nonzero_idle", idle_txd_err, 0);
        nwords = (l + 1) / 2;
        check("rd_count", rd_cyc_q.size(), nwords);
        n_chk = (rd_cyc_q.size() < nwords) ? rd_cyc_q.size() : nwords;
        n_bad = 0;
        for (int n = 0; n < n_chk; n++) begin
            if (rd_cyc_q[n] != t + 7 + 2 * n || rd_addr_q[n] !== 12'(TB_BASE + 12'(n))) n_bad++;
        end
        check("rd_sequence_bad", n_bad, 0);
        if (l > 0) check("tx_timestamp", tx_timestamp, gc_base + 64'(t + 8) * 64'd7);
`ifdef TX_CRC_GEN_EN
        if (wire_q.size() > 8) begin
            rc = 32'hFFFFFFFF;
            for (int i = 8; i < wire_q.size(); i++) rc = crc_byte(rc, wire_q[i]);
            check("fcs_residue", bitrev(rc), TB_RESIDUE);
        end
`else
        rc = 32'd0;
`endif
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        sys_rst      = 1'b1;
        tx_start     = 1'b0;
        tx_frame_len = 12'd0;
        gc_base      = {32'($urandom), 32'($urandom)};
        fill_random();
        repeat (3) @(negedge gmii_tx_clk);

        // Reset state
        check("rst_tx_en", gmii_tx_en, 0);
        check("rst_txd", gmii_txd, 0);
        check("rst_rd_en", slot_tx_eth_rd_en, 0);
        check("rst_address", slot_tx_eth_address, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_timestamp", tx_timestamp, 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge gmii_tx_clk);

        // Incrementing payload, 64 bytes, address range wraps past 4095
        for (int n = 0; n < 32; n++) mem[12'(TB_BASE + 12'(n))] = {8'(2 * n + 1), 8'(2 * n)};
        run_frame(64, 1'b0);

        fill_random();
        run_frame(5, 1'b0);
        run_frame(0, 1'b0);

        // Oversize request, extra start pulses mid-frame and on the last IFG cycle
        fill_random();
        run_frame(2000, 1'b1);

`ifdef TX_CRC_GEN_EN
        fill_random();
        run_frame(42, 1'b0);
`endif

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_frame(int'($urandom_range(1, 130)), 1'b0);
        end

        // Asynchronous reset during data byte 10, then a clean frame
        fill_random();
        @(negedge gmii_tx_clk);
        t = int'(cyc);
        tx_frame_len = 12'd60;
        tx_start = 1'b1;
        @(negedge gmii_tx_clk);
        tx_start = 1'b0;
        for (int k = 0; k < 40 && int'(cyc) < t + 19; k++) @(negedge gmii_tx_clk);
        check("pre_rst_tx_en", gmii_tx_en, 1);
        check("pre_rst_rd_en", slot_tx_eth_rd_en, 1);
        sys_rst = 1'b1;
        #1;
        check("midrst_tx_en", gmii_tx_en, 0);
        check("midrst_txd", gmii_txd, 0);
        check("midrst_rd_en", slot_tx_eth_rd_en, 0);
        check("midrst_busy", tx_busy, 0);
        repeat (3) @(negedge gmii_tx_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge gmii_tx_clk);
        fill_random();
        run_frame(60, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
